// File: rtl/vga_bus_receiver_pkg.sv
// vga_bus_receiver_pkg
// Shared definitions for the VGA draw-bus receiver:
//   - drain FSM state encoding
//   - pixel entry layout {y, x, rgb} stored in the pixel FIFO
//   - default framebuffer row pitch
//   - pixel_addr(): framebuffer address y*pitch + x, truncated to 16 bits
package vga_bus_receiver_pkg;

   localparam int X_W     = 8;
   localparam int Y_W     = 8;
   localparam int RGB_W   = 24;
   localparam int ENTRY_W = Y_W + X_W + RGB_W;
   localparam int ADDR_W  = 16;

   localparam int unsigned DEFAULT_FB_WIDTH = 256;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } drain_state_t;

   typedef struct packed {
      logic [Y_W-1:0]   y;
      logic [X_W-1:0]   x;
      logic [RGB_W-1:0] rgb;
   } pixel_entry_t;

   // The product is formed at 32 bits and the upper bits are discarded,
   // so addresses wrap modulo 2^16 for any pitch.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y,
                                                    input int unsigned    pitch);
      return ADDR_W'(32'(y) * pitch + 32'(x));
   endfunction

endpackage

// File: rtl/vga_bus_receiver_if.sv
// vga_bus_receiver_if
// Shared draw bus carrying one pixel per strobe.
//   vga_x_in_bus        8  pixel x
//   vga_y_in_bus        8  pixel y
//   vga_RGB_in_bus     24  pixel colour {R,G,B}
//   vga_draw_enable_bus 1  pixel-valid strobe (may float to z when undriven)
// master: the drawing agent; slave: the receiver.
interface vga_bus_receiver_if;
   logic [7:0]  vga_x_in_bus;
   logic [7:0]  vga_y_in_bus;
   logic [23:0] vga_RGB_in_bus;
   logic        vga_draw_enable_bus;

   modport master (
      output vga_x_in_bus,
      output vga_y_in_bus,
      output vga_RGB_in_bus,
      output vga_draw_enable_bus
   );

   modport slave (
      input vga_x_in_bus,
      input vga_y_in_bus,
      input vga_RGB_in_bus,
      input vga_draw_enable_bus
   );
endinterface

// File: rtl/vga_bus_receiver_pixel_fifo.sv
// pixel_fifo
// Synchronous FIFO of pixel entries with a look-ahead read port.
// Ports:
//   clk, reset            clock, async active-high reset
//   push, push_data       write request and entry
//   pop                   read request (consumes head_data)
//   head_data             current head entry
//   next_data             entry that becomes head after a pop this cycle
//   full, empty, last     occupancy flags (last = exactly one entry)
// Parameter DEPTH must be a power of two >= 2; pointers wrap naturally.
module pixel_fifo
   import vga_bus_receiver_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head_data,
   output logic [ENTRY_W-1:0] next_data,
   output logic               full,
   output logic               empty,
   output logic               last
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic [AW-1:0]      rd_next;
   logic               do_push, do_pop;

   always_comb begin
      full    = (count_q == FULL_CNT);
      empty   = (count_q == '0);
      last    = (count_q == ONE_CNT);
      do_pop  = pop && !empty;
      // A pop frees the slot being written, so a push on a full FIFO
      // still succeeds when it coincides with a pop.
      do_push = push && (!full || do_pop);
      rd_next = rd_ptr_q + 1'b1;

      rd_ptr_d = do_pop  ? rd_next : rd_ptr_q;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end

      head_data = mem_q[rd_ptr_q];
      // With a single entry left, the next head can only be the entry
      // being pushed right now (not yet visible in the array).
      next_data = (count_q > ONE_CNT) ? mem_q[rd_next] : push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

endmodule

// File: rtl/vga_bus_receiver.sv
// vga_bus_receiver
// Captures pixels from a shared draw bus into a FIFO and drains them to a
// framebuffer write port with ready backpressure, plus a flush handshake.
// Ports:
//   clk, reset                 clock, async active-high reset
//   draw_bus (slave)           x/y/RGB/strobe from the shared draw bus
//   fb_addr, fb_data, fb_we    framebuffer write request (held until fb_ready)
//   fb_ready                   framebuffer accepts the write this cycle
//   flush / flush_done         drain request / one-cycle completion pulse
//   busy                       FIFO non-empty or write pending
//   overflow                   sticky: a pixel was dropped on a full FIFO
// Build option: define VGA_RX_COLOR_DOWNCONVERT_EN to reduce each colour
// channel to its MSB replicated over 8 bits (3-bit colour adapter).
module vga_bus_receiver
   import vga_bus_receiver_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter int unsigned FB_WIDTH   = DEFAULT_FB_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   vga_bus_receiver_if.slave   draw_bus,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [RGB_W-1:0]    fb_data,
   output logic                fb_we,
   input  logic                fb_ready,
   input  logic                flush,
   output logic                flush_done,
   output logic                busy,
   output logic                overflow
);

   function automatic logic [RGB_W-1:0] to_fb_data(input logic [RGB_W-1:0] rgb);
`ifdef VGA_RX_COLOR_DOWNCONVERT_EN
      return {{8{rgb[23]}}, {8{rgb[15]}}, {8{rgb[7]}}};
`else
      return rgb;
`endif
   endfunction

   drain_state_t       state_q, state_d;
   logic               fb_we_q, fb_we_d;
   logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
   logic [RGB_W-1:0]   fb_data_q, fb_data_d;
   logic               flush_done_q, flush_done_d;
   logic               flush_lat_q, flush_lat_d;
   logic               overflow_q, overflow_d;

   logic               strobe_ok, pop, drained, flush_req;
   logic               fifo_full, fifo_empty, fifo_last;
   logic [ENTRY_W-1:0] push_data, head_data, next_data;
   pixel_entry_t       head_entry, next_entry;

   // Only a solid 1 counts as a strobe; a floating or unknown bus is ignored.
   assign strobe_ok  = (draw_bus.vga_draw_enable_bus === 1'b1);
   assign push_data  = {draw_bus.vga_y_in_bus, draw_bus.vga_x_in_bus, draw_bus.vga_RGB_in_bus};
   assign head_entry = head_data;
   assign next_entry = next_data;
   assign pop        = (state_q == S_WRITE) && fb_we_q && fb_ready;
   // The last entry leaves and nothing arrives to replace it.
   assign drained    = fifo_last && !strobe_ok;
   assign flush_req  = flush || flush_lat_q;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (strobe_ok),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .next_data (next_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .last      (fifo_last)
   );

   // Drain FSM: the output registers always mirror the FIFO head while
   // in S_WRITE, so a pop reloads them with the following entry to keep
   // back-to-back writes without a bubble.
   always_comb begin
      state_d      = state_q;
      fb_we_d      = fb_we_q;
      fb_addr_d    = fb_addr_q;
      fb_data_d    = fb_data_q;
      flush_done_d = 1'b0;
      flush_lat_d  = flush_lat_q | flush;
      overflow_d   = overflow_q | (strobe_ok && fifo_full && !pop);

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d   = S_WRITE;
               fb_we_d   = 1'b1;
               fb_addr_d = pixel_addr(head_entry.x, head_entry.y, FB_WIDTH);
               fb_data_d = to_fb_data(head_entry.rgb);
            end else if (flush_req) begin
               state_d = S_DONE;
            end
         end
         S_WRITE: begin
            if (pop) begin
               if (drained) begin
                  fb_we_d = 1'b0;
                  state_d = flush_req ? S_FLUSH : S_IDLE;
               end else begin
                  fb_addr_d = pixel_addr(next_entry.x, next_entry.y, FB_WIDTH);
                  fb_data_d = to_fb_data(next_entry.rgb);
               end
            end
         end
         S_FLUSH: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            flush_done_d = 1'b1;
            flush_lat_d  = flush;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fb_we_q      <= 1'b0;
         fb_addr_q    <= '0;
         fb_data_q    <= '0;
         flush_done_q <= 1'b0;
         flush_lat_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         flush_done_q <= flush_done_d;
         flush_lat_q  <= flush_lat_d;
         overflow_q   <= overflow_d;
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign flush_done = flush_done_q;
   assign overflow   = overflow_q;
   assign busy       = !fifo_empty || fb_we_q;

endmodule

// File: tb/tb_vga_bus_receiver.sv
// tb_vga_bus_receiver
// Directed bench for vga_bus_receiver (FIFO_DEPTH=8, FB_WIDTH=256).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_bus_receiver;
   import vga_bus_receiver_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] fb_addr;
   logic [23:0] fb_data;
   logic        fb_we;
   logic        fb_ready;
   logic        flush;
   logic        flush_done;
   logic        busy;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  px [4];
   logic [7:0]  py [4];
   logic [23:0] pc [4];

   always #5 clk = ~clk;

   vga_bus_receiver_if draw_bus ();

   vga_bus_receiver #(
      .FIFO_DEPTH (8),
      .FB_WIDTH   (256)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .draw_bus   (draw_bus),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_we      (fb_we),
      .fb_ready   (fb_ready),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy),
      .overflow   (overflow)
   );

   function automatic logic [31:0] expColor(input logic [23:0] rgb);
`ifdef VGA_RX_COLOR_DOWNCONVERT_EN
      return {8'h00, {8{rgb[23]}}, {8{rgb[15]}}, {8{rgb[7]}}};
`else
      return {8'h00, rgb};
`endif
   endfunction

   function automatic logic [31:0] expAddr(input logic [7:0] x, input logic [7:0] y);
      return {16'h0000, y, x};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y,
                                input logic [23:0] rgb, input logic en);
      draw_bus.vga_x_in_bus        = x;
      draw_bus.vga_y_in_bus        = y;
      draw_bus.vga_RGB_in_bus      = rgb;
      draw_bus.vga_draw_enable_bus = en;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      px[0] = 8'h10; py[0] = 8'h01; pc[0] = 24'h112233;
      px[1] = 8'h11; py[1] = 8'h02; pc[1] = 24'h445566;
      px[2] = 8'h12; py[2] = 8'h03; pc[2] = 24'h778899;
      px[3] = 8'h13; py[3] = 8'h04; pc[3] = 24'hAABBCC;

      // Reset state
      reset    = 1'b1;
      fb_ready = 1'b0;
      flush    = 1'b0;
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      tick();
      tick();
      checkOutput("rst_we",       32'(fb_we),      32'h0);
      checkOutput("rst_addr",     32'(fb_addr),    32'h0);
      checkOutput("rst_data",     32'(fb_data),    32'h0);
      checkOutput("rst_done",     32'(flush_done), 32'h0);
      checkOutput("rst_busy",     32'(busy),       32'h0);
      checkOutput("rst_overflow", 32'(overflow),   32'h0);
      reset = 1'b0;
      tick();

      // Single pixel, framebuffer ready: write appears one cycle after capture
      fb_ready = 1'b1;
      applyStimulus(8'd3, 8'd5, 24'hFF0000, 1'b1);
      tick();
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      checkOutput("single_we_early", 32'(fb_we), 32'h0);
      checkOutput("single_busy",     32'(busy),  32'h1);
      tick();
      checkOutput("single_we",   32'(fb_we),   32'h1);
      checkOutput("single_addr", 32'(fb_addr), 32'h0503);
      checkOutput("single_data", 32'(fb_data), expColor(24'hFF0000));
      tick();
      checkOutput("single_we_end",   32'(fb_we), 32'h0);
      checkOutput("single_busy_end", 32'(busy),  32'h0);

      // Backpressure: four pixels held behind a stalled framebuffer
      fb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(px[i], py[i], pc[i], 1'b1);
         tick();
      end
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp_hold_we%0d", c),   32'(fb_we),   32'h1);
         checkOutput($sformatf("bp_hold_addr%0d", c), 32'(fb_addr), expAddr(px[0], py[0]));
         checkOutput($sformatf("bp_hold_data%0d", c), 32'(fb_data), expColor(pc[0]));
         tick();
      end
      fb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("bp_we%0d", i),   32'(fb_we),   32'h1);
         checkOutput($sformatf("bp_addr%0d", i), 32'(fb_addr), expAddr(px[i], py[i]));
         checkOutput($sformatf("bp_data%0d", i), 32'(fb_data), expColor(pc[i]));
         checkOutput($sformatf("bp_busy%0d", i), 32'(busy),    32'h1);
         tick();
      end
      checkOutput("bp_we_end",   32'(fb_we), 32'h0);
      checkOutput("bp_busy_end", 32'(busy),  32'h0);

      // Overflow: nine strobes into an eight-entry FIFO with no drain
      fb_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(8'(8'h40 + i), 8'h20, 24'(24'h0A0B00 + i), 1'b1);
         tick();
         checkOutput($sformatf("ovf_flag%0d", i), 32'(overflow), (i == 8) ? 32'h1 : 32'h0);
      end
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      fb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("ovf_we%0d", i),   32'(fb_we),   32'h1);
         checkOutput($sformatf("ovf_addr%0d", i), 32'(fb_addr), expAddr(8'(8'h40 + i), 8'h20));
         tick();
      end
      checkOutput("ovf_ninth_not_written", 32'(fb_we),    32'h0);
      checkOutput("ovf_busy_end",          32'(busy),     32'h0);
      checkOutput("ovf_sticky",            32'(overflow), 32'h1);

      // Flush with three buffered pixels, requested while stalled
      fb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'(8'h80 + i), 8'(8'h30 + i), 24'(24'h00FF00 + i), 1'b1);
         tick();
      end
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      fb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("fl_we%0d", i),   32'(fb_we),      32'h1);
         checkOutput($sformatf("fl_addr%0d", i), 32'(fb_addr),    expAddr(8'(8'h80 + i), 8'(8'h30 + i)));
         checkOutput($sformatf("fl_done%0d", i), 32'(flush_done), 32'h0);
         tick();
      end
      checkOutput("fl_flush_we",    32'(fb_we),      32'h0);
      checkOutput("fl_flush_done0", 32'(flush_done), 32'h0);
      checkOutput("fl_flush_busy",  32'(busy),       32'h0);
      tick();
      checkOutput("fl_done_state",  32'(flush_done), 32'h0);
      tick();
      checkOutput("fl_done_pulse",  32'(flush_done), 32'h1);
      tick();
      checkOutput("fl_done_clear",  32'(flush_done), 32'h0);

      // Flush with an empty FIFO: completion two cycles after the request
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("efl_done_c1", 32'(flush_done), 32'h0);
      tick();
      checkOutput("efl_done_c2", 32'(flush_done), 32'h1);
      tick();
      checkOutput("efl_done_c3", 32'(flush_done), 32'h0);

      // Floating draw bus must never be captured
      draw_bus.vga_x_in_bus        = 8'hzz;
      draw_bus.vga_y_in_bus        = 8'hzz;
      draw_bus.vga_RGB_in_bus      = 24'hzzzzzz;
      draw_bus.vga_draw_enable_bus = 1'bz;
      for (int c = 0; c < 10; c++) begin
         tick();
         checkOutput($sformatf("busz_we%0d", c), 32'(fb_we), 32'h0);
      end
      checkOutput("busz_busy", 32'(busy), 32'h0);
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);

      // Reset in the middle of a drain discards everything
      fb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(8'hC0 + i), 8'h50, 24'hABCDEF, 1'b1);
         tick();
      end
      applyStimulus(8'h00, 8'h00, 24'h000000, 1'b0);
      checkOutput("mid_we_before",   32'(fb_we), 32'h1);
      checkOutput("mid_busy_before", 32'(busy),  32'h1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_we",       32'(fb_we),      32'h0);
      checkOutput("mid_rst_addr",     32'(fb_addr),    32'h0);
      checkOutput("mid_rst_data",     32'(fb_data),    32'h0);
      checkOutput("mid_rst_busy",     32'(busy),       32'h0);
      checkOutput("mid_rst_overflow", 32'(overflow),   32'h0);
      checkOutput("mid_rst_done",     32'(flush_done), 32'h0);
      tick();
      reset    = 1'b0;
      fb_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("mid_post_we%0d", c),   32'(fb_we), 32'h0);
         checkOutput($sformatf("mid_post_busy%0d", c), 32'(busy),  32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
